// File: rtl/data_mem_responder_if.sv
// Data-port bus between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, busy, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, busy, err);
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state memory responder: IDLE -> WAIT -> RESP over a word-addressed internal RAM.
// Optional misaligned-access flagging is enabled by defining MISALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic            r_we, r_mis;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [31:0]     r_ram [DEPTH_WORDS];

  logic            w_accept, w_enter_resp, w_ram_we;
  logic            w_we, w_mis, w_addr_mis;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;
  logic            w_unused_addr;

`ifdef MISALIGN_CHECK_EN
  assign w_addr_mis = (bus.addr[1:0] != 2'b00);
`else
  assign w_addr_mis = 1'b0;
`endif

  assign w_unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          w_cnt_next   = WS;
          w_state_next = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accept edge itself, so take
  // the access attributes straight from the bus in that case.
  assign w_accept     = (r_state == S_IDLE) && bus.req;
  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
  assign w_we         = w_accept ? bus.we : r_we;
  assign w_idx        = w_accept ? bus.addr[AW+1:2] : r_idx;
  assign w_wdata      = w_accept ? bus.wdata : r_wdata;
  assign w_mis        = w_accept ? w_addr_mis : r_mis;
  assign w_ram_we     = reset && w_enter_resp && w_we && !w_mis;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we    <= bus.we;
        r_mis   <= w_addr_mis;
        r_idx   <= bus.addr[AW+1:2];
        r_wdata <= bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_idx] <= w_wdata;
  end

  // Registered read port; a store leaves rdata holding the previous load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else if (w_enter_resp) begin
      if (w_mis)      r_rdata <= 32'd0;
      else if (!w_we) r_rdata <= r_ram[w_idx];
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = (r_state == S_RESP);
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.err   = (r_state == S_RESP) && r_mis;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: word array indexed modulo the depth, plus the last rdata.
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
`ifdef MISALIGN_CHECK_EN
  bit m_mis_en = 1'b1;
`else
  bit m_mis_en = 1'b0;
`endif

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd, output logic exp_err);
    bit mis;
    mis = m_mis_en && ((a % 4) != 0);
    exp_err = mis;
    if (mis) m_rdata = 32'd0;
    else if (w) m_mem[widx(a)] = d;
    else if (m_mem.exists(widx(a))) m_rdata = m_mem[widx(a)];
    else m_rdata = 'x;
    exp_rd = m_rdata;
  endtask

  // Drives one access from IDLE and observes until ready (bounded).
  task automatic drive_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output int lat, output bit busy_ok, output bit err_ok,
                              output logic [31:0] rd, output logic e);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    lat = 0; busy_ok = 1'b1; err_ok = 1'b1; rd = 'x; e = 'x;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.ready === 1'b1) begin
        lat = c; rd = bus.rdata; e = bus.err;
        break;
      end
      if (bus.err !== 1'b0) err_ok = 1'b0;
      @(negedge clk);
    end
    $display("access we=%0b addr=%08h wdata=%08h lat=%0d rdata=%08h err=%0b", w, a, d, lat, rd, e);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h10; bus.wdata = 32'h1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({bus.ready, bus.busy, bus.err} !== 3'b000 || bus.rdata !== 32'd0)
        $display("FAIL reset_outputs cycle %0d: ready=%b busy=%b err=%b rdata=%08h, want 0/0/0/00000000",
                 i, bus.ready, bus.busy, bus.err, bus.rdata);
      else n_pass++;
    end
    bus.req = 1'b0;
    reset = 1'b1;
    m_rdata = 32'd0;
  endtask

  task automatic test_store_load;
    logic [31:0] ta [4] = '{32'h10, 32'h10, 32'h104, 32'h004};
    logic [31:0] td [4] = '{32'hDEADBEEF, 32'h0, 32'h12345678, 32'h0};
    logic        tw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int lat; bit bok, eok; logic [31:0] rd, erd; logic e, ee;
    for (int i = 0; i < 4; i++) begin
      drive_access(tw[i], ta[i], td[i], lat, bok, eok, rd, e);
      model_access(tw[i], ta[i], td[i], erd, ee);
      n_total++;
      if (lat != WS + 1 || !bok || !eok)
        $display("FAIL store_load[%0d] timing: lat=%0d busy_ok=%0b err_ok=%0b, want lat=%0d 1 1", i, lat, bok, eok, WS + 1);
      else n_pass++;
      n_total++;
      if (rd !== erd || e !== ee)
        $display("FAIL store_load[%0d] data: rdata=%08h err=%b, want %08h %b", i, rd, e, erd, ee);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [2] = '{32'h10, 32'h004};
    int k = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a[0]; bus.wdata = 32'h0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.ready !== ((c % (WS + 2)) == WS + 1) || bus.busy !== (c % (WS + 2) != 0))
        $display("FAIL back_to_back cycle %0d: ready=%b busy=%b, want %b %b", c, bus.ready, bus.busy,
                 (c % (WS + 2)) == WS + 1, c % (WS + 2) != 0);
      else n_pass++;
      if (bus.ready === 1'b1) begin
        $display("back_to_back load addr=%08h rdata=%08h", a[k % 2], bus.rdata);
        n_total++;
        if (bus.rdata !== m_mem[widx(a[k % 2])])
          $display("FAIL back_to_back rdata #%0d: got %08h, want %08h", k, bus.rdata, m_mem[widx(a[k % 2])]);
        else n_pass++;
        m_rdata = m_mem[widx(a[k % 2])];
        k++;
        bus.addr = a[k % 2];
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lat; bit bok, eok; logic [31:0] rd, erd; logic e, ee;
    bit saw_ready = 1'b0;
    drive_access(1'b1, 32'h20, 32'hA5A50020, lat, bok, eok, rd, e);
    model_access(1'b1, 32'h20, 32'hA5A50020, erd, ee);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'h0BAD0BAD;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_rdata = 32'd0;
    n_total++;
    if (bus.busy !== 1'b0 || bus.rdata !== 32'd0)
      $display("FAIL reset_abort state: busy=%b rdata=%08h, want 0 00000000", bus.busy, bus.rdata);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (bus.ready === 1'b1) saw_ready = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (saw_ready) $display("FAIL reset_abort ready: got pulse, want none");
    else n_pass++;
    drive_access(1'b0, 32'h20, 32'h0, lat, bok, eok, rd, e);
    model_access(1'b0, 32'h20, 32'h0, erd, ee);
    n_total++;
    if (rd !== erd || lat != WS + 1)
      $display("FAIL reset_abort reload: rdata=%08h lat=%0d, want %08h %0d", rd, lat, erd, WS + 1);
    else n_pass++;
  endtask

  task automatic test_misalign;
    logic [31:0] ta [2] = '{32'h22, 32'h20};
    logic        tw [2] = '{1'b1, 1'b0};
    int lat; bit bok, eok; logic [31:0] rd, erd; logic e, ee;
    for (int i = 0; i < 2; i++) begin
      drive_access(tw[i], ta[i], 32'hCAFEF00D, lat, bok, eok, rd, e);
      model_access(tw[i], ta[i], 32'hCAFEF00D, erd, ee);
      n_total++;
      if (lat != WS + 1 || !eok || rd !== erd || e !== ee)
        $display("FAIL misalign[%0d]: lat=%0d err_ok=%0b rdata=%08h err=%b, want %0d 1 %08h %b",
                 i, lat, eok, rd, e, WS + 1, erd, ee);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int lat; bit bok, eok; logic [31:0] rd, erd, a, d; logic e, ee, w;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (!w && !m_mem.exists(widx(a))) w = 1'b1;
      drive_access(w, a, d, lat, bok, eok, rd, e);
      model_access(w, a, d, erd, ee);
      n_total++;
      if (lat != WS + 1 || !bok || !eok || rd !== erd || e !== ee)
        $display("FAIL random[%0d] we=%0b addr=%08h: lat=%0d busy_ok=%0b err_ok=%0b rdata=%08h err=%b, want lat=%0d %08h %b",
                 i, w, a, lat, bok, eok, rd, e, WS + 1, erd, ee);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_reset_abort();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
